// File: rtl/hazard_pkg.sv
// Shared encodings for the hazard scheduler: FSM states, forwarding selects,
// jump codes and control-field bit positions (decoder polarity, active-low).
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        MEM_WAIT = 2'b01,
        MEM_DONE = 2'b10
    } sched_state_e;

    localparam logic [1:0] FWD_BANK  = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    localparam logic [1:0] SEL_SEQ = 2'b00;
    localparam logic [1:0] SEL_J   = 2'b01;
    localparam logic [1:0] SEL_JR  = 2'b10;

    // ctrl_MEM = {MEM_RD, MEM_WR, w_h}, ctrl_WB = {DIR_WB, REG_WR}
    localparam int MEM_RD_BIT = 2;
    localparam int MEM_WR_BIT = 1;
    localparam int WH_BIT     = 0;
    localparam int DIR_WB_BIT = 1;
    localparam int REG_WR_BIT = 0;

    localparam logic ACTIVO = 1'b0;

    // A stage really writes the bank only when REG_WR is active and dst is not $0.
    function automatic logic valid_writer(input logic reg_wr, input logic [4:0] dst);
        return (reg_wr == ACTIVO) && (dst != 5'd0);
    endfunction

endpackage

// File: rtl/hazard_fwd.sv
// Forwarding select for one ALU operand: EX/MEM result wins over MEM/WB,
// otherwise the operand comes from the register bank.
module hazard_fwd
    import hazard_pkg::*;
(
    input  logic [4:0] src,
    input  logic [4:0] mem_dst,
    input  logic       mem_fwd_ok,
    input  logic [4:0] wb_dst,
    input  logic       wb_fwd_ok,
    output logic [1:0] fwd
);

    // Priority compare against the two younger-to-older producers.
    always_comb begin
        fwd = FWD_BANK;
        if (mem_fwd_ok && (mem_dst == src)) begin
            fwd = FWD_EXMEM;
        end else if (wb_fwd_ok && (wb_dst == src)) begin
            fwd = FWD_MEMWB;
        end else begin
            fwd = FWD_BANK;
        end
    end

endmodule

// File: rtl/hazard_sched.sv
// Pipeline scheduler: pipe enables/flush, ID hazards, EXE forwarding and the
// data-memory handshake. Define HAZARD_FWD_EN to enable EXE forwarding.
module hazard_sched
    import hazard_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_reg_rd,
    input  logic       id_use_rt,
    input  logic [1:0] id_sel_dir,
    input  logic [4:0] ex_dst,
    input  logic [2:0] ex_ctrl_mem,
    input  logic [1:0] ex_ctrl_wb,
    input  logic [4:0] mem_dst,
    input  logic [2:0] mem_ctrl_mem,
    input  logic [1:0] mem_ctrl_wb,
    input  logic [4:0] wb_dst,
    input  logic [1:0] wb_ctrl_wb,
    input  logic [4:0] ex_src_a,
    input  logic [4:0] ex_src_b,
    input  logic       dmem_ack,
    output logic       dmem_req,
    output logic       pc_en,
    output logic       ifid_en,
    output logic       ifid_flush,
    output logic       idex_bubble,
    output logic       exmem_en,
    output logic       memwb_en,
    output logic [1:0] fwd_a,
    output logic [1:0] fwd_b,
    output logic       mem_err
);

    sched_state_e     state_r;
    sched_state_e     state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic             mem_err_r;

    logic ex_wr_s, mem_wr_s, wb_wr_s;
    logic ex_load_s, mem_acc_s, mem_fwd_ok_s;
    logic rs_ex_s, rt_ex_s, rs_mem_s, rt_mem_s;
    logic load_use_s, jr_haz_s, src_haz_s, id_stall_s, id_flush_s;
    logic timeout_s;
    logic [1:0] fwd_a_s, fwd_b_s;

    assign ex_wr_s   = valid_writer(ex_ctrl_wb[REG_WR_BIT], ex_dst);
    assign mem_wr_s  = valid_writer(mem_ctrl_wb[REG_WR_BIT], mem_dst);
    assign wb_wr_s   = valid_writer(wb_ctrl_wb[REG_WR_BIT], wb_dst);
    assign ex_load_s = (ex_ctrl_mem[MEM_RD_BIT] == ACTIVO);
    assign mem_acc_s = (mem_ctrl_mem[MEM_RD_BIT] == ACTIVO) || (mem_ctrl_mem[MEM_WR_BIT] == ACTIVO);
    // A load in EX/MEM has no data yet, so it may only be forwarded from MEM/WB.
    assign mem_fwd_ok_s = mem_wr_s && (mem_ctrl_mem[MEM_RD_BIT] != ACTIVO);

    assign rs_ex_s  = ex_wr_s  && (id_reg_rd == ACTIVO) && (ex_dst == id_rs);
    assign rt_ex_s  = ex_wr_s  && id_use_rt && (ex_dst == id_rt);
    assign rs_mem_s = mem_wr_s && (id_reg_rd == ACTIVO) && (mem_dst == id_rs);
    assign rt_mem_s = mem_wr_s && id_use_rt && (mem_dst == id_rt);

    assign load_use_s = ex_load_s && (rs_ex_s || rt_ex_s);
    assign jr_haz_s   = (id_sel_dir == SEL_JR) &&
                        ((ex_wr_s && (ex_dst == id_rs)) || (mem_wr_s && (mem_dst == id_rs)));
`ifdef HAZARD_FWD_EN
    assign src_haz_s = 1'b0;
`else
    assign src_haz_s = rs_ex_s || rt_ex_s || rs_mem_s || rt_mem_s;
`endif
    assign id_stall_s = load_use_s || jr_haz_s || src_haz_s;
    assign id_flush_s = !id_stall_s && (id_sel_dir != SEL_SEQ);
    assign timeout_s  = (cnt_r == CNT_W'(MEM_TIMEOUT - 1));

    hazard_fwd u_fwd_a (
        .src        (ex_src_a),
        .mem_dst    (mem_dst),
        .mem_fwd_ok (mem_fwd_ok_s),
        .wb_dst     (wb_dst),
        .wb_fwd_ok  (wb_wr_s),
        .fwd        (fwd_a_s)
    );

    hazard_fwd u_fwd_b (
        .src        (ex_src_b),
        .mem_dst    (mem_dst),
        .mem_fwd_ok (mem_fwd_ok_s),
        .wb_dst     (wb_dst),
        .wb_fwd_ok  (wb_wr_s),
        .fwd        (fwd_b_s)
    );

    // State, wait counter and sticky timeout flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= RUN;
            cnt_r     <= '0;
            mem_err_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if (state_r == MEM_WAIT) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end else begin
                cnt_r <= '0;
            end
            if ((state_r == MEM_WAIT) && !dmem_ack && timeout_s) begin
                mem_err_r <= 1'b1;
            end else begin
                mem_err_r <= mem_err_r;
            end
        end
    end

    // Next state and Mealy pipe controls; rst_n low forces the idle controls at once.
    always_comb begin
        state_nxt_s = state_r;
        dmem_req    = 1'b0;
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        exmem_en    = 1'b1;
        memwb_en    = 1'b1;
        fwd_a       = FWD_BANK;
        fwd_b       = FWD_BANK;
        if (rst_n) begin
`ifdef HAZARD_FWD_EN
            fwd_a = fwd_a_s;
            fwd_b = fwd_b_s;
`endif
            case (state_r)
                RUN: begin
                    if (mem_acc_s) begin
                        state_nxt_s = MEM_WAIT;
                        dmem_req    = 1'b1;
                        pc_en       = 1'b0;
                        ifid_en     = 1'b0;
                        exmem_en    = 1'b0;
                        memwb_en    = 1'b0;
                    end else begin
                        state_nxt_s = RUN;
                        pc_en       = !id_stall_s;
                        ifid_en     = !id_stall_s;
                        idex_bubble = id_stall_s;
                        ifid_flush  = id_flush_s;
                    end
                end
                MEM_WAIT: begin
                    dmem_req = 1'b1;
                    pc_en    = 1'b0;
                    ifid_en  = 1'b0;
                    exmem_en = 1'b0;
                    memwb_en = 1'b0;
                    if (dmem_ack || timeout_s) begin
                        state_nxt_s = MEM_DONE;
                    end else begin
                        state_nxt_s = MEM_WAIT;
                    end
                end
                MEM_DONE: begin
                    // The whole pipe advances here, so ID hazards still have to hold IF/ID.
                    state_nxt_s = RUN;
                    pc_en       = !id_stall_s;
                    ifid_en     = !id_stall_s;
                    idex_bubble = id_stall_s;
                    ifid_flush  = id_flush_s;
                end
                default: begin
                    state_nxt_s = RUN;
                end
            endcase
        end else begin
            state_nxt_s = RUN;
        end
    end

    assign mem_err = mem_err_r;

    logic unused_ctrl_s;
    assign unused_ctrl_s = ^{ex_ctrl_mem[MEM_WR_BIT], ex_ctrl_mem[WH_BIT], mem_ctrl_mem[WH_BIT],
                             ex_ctrl_wb[DIR_WB_BIT], mem_ctrl_wb[DIR_WB_BIT], wb_ctrl_wb[DIR_WB_BIT]};
`ifndef HAZARD_FWD_EN
    logic unused_fwd_s;
    assign unused_fwd_s = ^{fwd_a_s, fwd_b_s};
`endif

endmodule
